// File: rtl/cga_composite_enc_if.sv
// Bundle of CGA composite encoder pixel/sync inputs and composite/sync outputs.
// The master side (pixel pipeline) drives the inputs; the encoder is the slave.
interface cga_composite_enc_if #(
  parameter int OUT_W = 7
);
  logic             hclk_ce;
  logic             lclk_ce;
  logic [3:0]       video;
  logic             hsync;
  logic             vsync_l;
  logic             bw_mode;
  logic             new_cga;
  logic [2:0]       hue;
  logic             hsync_out;
  logic             vsync_out;
  logic             csync_out;
  logic [OUT_W-1:0] comp_video;
  logic             pix_strobe;

  modport master (
    output hclk_ce, lclk_ce, video, hsync, vsync_l, bw_mode, new_cga, hue,
    input  hsync_out, vsync_out, csync_out, comp_video, pix_strobe
  );

  modport slave (
    input  hclk_ce, lclk_ce, video, hsync, vsync_l, bw_mode, new_cga, hue,
    output hsync_out, vsync_out, csync_out, comp_video, pix_strobe
  );
endinterface

// File: rtl/cga_composite_enc.sv
// NTSC composite encoder for the CGA video path. Turns latched IRGB pixels into a
// digital composite sample (luma + square-wave chroma carrier), and shapes the CRTC
// syncs into hsync/vsync/csync with a colour burst window on the back porch.
module cga_composite_enc #(
  parameter int OUT_W    = 7,
  parameter int HS_START = 2,
  parameter int HS_END   = 6,
  parameter int BURST_LO = 7,
  parameter int BURST_HI = 8,
  parameter int HS_MAX   = 11,
  parameter int VS_LINES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  cga_composite_enc_if.slave    bus
);

  localparam int HC_W = $clog2(HS_MAX + 1);

  // Base luma for RGB 0..7 from the old or new CGA resistor network.
  function automatic logic [6:0] luma_lvl(input logic [2:0] rgb, input logic new_tbl);
    logic [6:0] y;
    case ({new_tbl, rgb})
      4'b0_000: y = 7'd29;
      4'b0_001: y = 7'd36;
      4'b0_010: y = 7'd49;
      4'b0_011: y = 7'd56;
      4'b0_100: y = 7'd39;
      4'b0_101: y = 7'd46;
      4'b0_110: y = 7'd60;
      4'b0_111: y = 7'd68;
      4'b1_000: y = 7'd29;
      4'b1_001: y = 7'd33;
      4'b1_010: y = 7'd45;
      4'b1_011: y = 7'd49;
      4'b1_100: y = 7'd41;
      4'b1_101: y = 7'd45;
      4'b1_110: y = 7'd57;
      4'b1_111: y = 7'd61;
      default:  y = 7'd0;
    endcase
    return y;
  endfunction

  // Square-wave carrier: high for the first half of the rotated 8-phase cycle.
  function automatic logic carrier_on(input logic [2:0] ph, input logic [2:0] ofs,
                                      input logic [2:0] rot);
    logic [2:0] s;
    s = ph + ofs + rot;
    return ~s[2];
  endfunction

  logic [2:0]      ph_q;
  logic [3:0]      vid_q;
  logic            hs_d_q;
  logic            vs_d_l_q;
  logic [HC_W-1:0] hc_q, hc_d;
  logic            vtrig_q, vtrig_d;
  logic [VS_LINES:0] sr_q, sr_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            csync_q, csync_d;
  logic [OUT_W-1:0] comp_q, comp_d;
  logic            burst_s;
  logic [2:0]      sel_s;
  logic            chroma_s;
  logic [6:0]      level_s;

  // Next-state for sync counter, vsync shaper and the composite sample.
  always_comb begin
    hc_d = hc_q;
    if (bus.lclk_ce) begin
      if (!hs_d_q) begin
        hc_d = '0;
      end else if (hc_q == HC_W'(HS_MAX)) begin
        hc_d = '0;
      end else begin
        hc_d = hc_q + HC_W'(1);
      end
    end else begin
      hc_d = hc_q;
    end

    vtrig_d = (hc_d == HC_W'(2)) && (hc_q != HC_W'(2));

    sr_d = sr_q;
    if (vtrig_q) begin
      if (vs_d_l_q) begin
        sr_d = {sr_q[VS_LINES-1:0], 1'b1};
      end else begin
        sr_d = '0;
      end
    end else begin
      sr_d = sr_q;
    end

    hsync_d = (hc_q >= HC_W'(HS_START)) && (hc_q < HC_W'(HS_END));
    vsync_d = sr_q[0] & ~sr_q[VS_LINES];
    csync_d = ~(hsync_d ^ vsync_d);

    burst_s = ~bus.bw_mode & ~vs_d_l_q &
              (hc_q >= HC_W'(BURST_LO)) & (hc_q <= HC_W'(BURST_HI));
    sel_s   = {vid_q[2] ^ burst_s, vid_q[1] ^ burst_s, vid_q[0]};

    chroma_s = 1'b0;
    if (bus.bw_mode) begin
      chroma_s = |vid_q[2:0];
    end else begin
      case (sel_s)
        3'd0:    chroma_s = 1'b0;
        3'd1:    chroma_s = carrier_on(ph_q, 3'd4, bus.hue);  // blue
        3'd2:    chroma_s = carrier_on(ph_q, 3'd7, bus.hue);  // green
        3'd3:    chroma_s = carrier_on(ph_q, 3'd6, bus.hue);  // cyan
        3'd4:    chroma_s = carrier_on(ph_q, 3'd2, bus.hue);  // red
        3'd5:    chroma_s = carrier_on(ph_q, 3'd3, bus.hue);  // magenta
        3'd6:    chroma_s = carrier_on(ph_q, 3'd0, bus.hue);  // yellow / burst
        3'd7:    chroma_s = 1'b1;
        default: chroma_s = 1'b0;
      endcase
    end

    level_s = luma_lvl(vid_q[2:0], bus.new_cga)
            + (vid_q[3] ? (bus.new_cga ? 7'd24 : 7'd31) : 7'd0)
            + (chroma_s ? 7'd28 : 7'd0);

    // Sync tip overrides video so the DAC sits at blank-below-black during sync.
    if (csync_d) begin
      comp_d = OUT_W'(level_s) << (OUT_W - 7);
    end else begin
      comp_d = '0;
    end
  end

  // State and registered outputs; sync samples and pixel latch gated by their strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      ph_q     <= '0;
      vid_q    <= '0;
      hs_d_q   <= 1'b0;
      vs_d_l_q <= 1'b0;
      hc_q     <= '0;
      vtrig_q  <= 1'b0;
      sr_q     <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      csync_q  <= 1'b0;
      comp_q   <= '0;
    end else begin
      ph_q <= ph_q + 3'd1;
      if (ph_q[0]) begin
        vid_q <= bus.video;
      end
      if (bus.hclk_ce) begin
        hs_d_q   <= bus.hsync;
        vs_d_l_q <= bus.vsync_l;
      end
      hc_q    <= hc_d;
      vtrig_q <= vtrig_d;
      sr_q    <= sr_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      csync_q <= csync_d;
      comp_q  <= comp_d;
    end
  end

  assign bus.hsync_out  = hsync_q;
  assign bus.vsync_out  = vsync_q;
  assign bus.csync_out  = csync_q;
  assign bus.comp_video = comp_q;
  assign bus.pix_strobe = ph_q[0];

endmodule

// File: tb/tb_cga_composite_enc.sv
// Randomized + directed bench for cga_composite_enc against a behavioural model.
module tb_cga_composite_enc;

  localparam int VS_LINES = 3;
  localparam int HS_MAX   = 11;

  logic clk;
  logic reset;
  cga_composite_enc_if #(.OUT_W(7)) bus();

  cga_composite_enc #(.OUT_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // behavioural model state
  int m_ph, m_vid, m_hs, m_vs, m_hc, m_vtrig, m_ones;
  int o_hs, o_vs, o_cs, o_comp;

  int luma_old [8] = '{29, 36, 49, 56, 39, 46, 60, 68};
  int luma_new [8] = '{29, 33, 45, 49, 41, 45, 57, 61};
  // carrier offset by colour select: blue 4, green 7, cyan 6, red 2, magenta 3, yellow 0
  int ofs_tab  [8] = '{0, 4, 7, 6, 2, 3, 0, 0};

  int prev_hs     = 0;
  int hs_rises    = 0;
  int hs_rises_vs = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_level(input int vid, input int ph, input int burst);
    int rgb, y, c, r, g, b, sel;
    rgb = vid & 7;
    y   = bus.new_cga ? luma_new[rgb] : luma_old[rgb];
    if (((vid >> 3) & 1) == 1) y += bus.new_cga ? 24 : 31;
    if (bus.bw_mode) begin
      c = (rgb != 0) ? 1 : 0;
    end else begin
      r   = ((rgb >> 2) & 1) ^ burst;
      g   = ((rgb >> 1) & 1) ^ burst;
      b   = rgb & 1;
      sel = r * 4 + g * 2 + b;
      if (sel == 0)      c = 0;
      else if (sel == 7) c = 1;
      else               c = (((ph + ofs_tab[sel] + int'(bus.hue)) % 8) < 4) ? 1 : 0;
    end
    return y + (c ? 28 : 0);
  endfunction

  task automatic model_step();
    int n_ph, n_vid, n_hs, n_vs, n_hc, n_vtrig, n_ones, burst;
    if (reset) begin
      m_ph = 0; m_vid = 0; m_hs = 0; m_vs = 0; m_hc = 0; m_vtrig = 0; m_ones = 0;
      o_hs = 0; o_vs = 0; o_cs = 0; o_comp = 0;
      return;
    end
    n_ph  = (m_ph + 1) % 8;
    n_vid = (m_ph % 2 == 1) ? int'(bus.video) : m_vid;
    n_hs  = bus.hclk_ce ? int'(bus.hsync)   : m_hs;
    n_vs  = bus.hclk_ce ? int'(bus.vsync_l) : m_vs;
    n_hc  = m_hc;
    if (bus.lclk_ce) n_hc = (m_hs == 0) ? 0 : ((m_hc == HS_MAX) ? 0 : m_hc + 1);
    n_vtrig = (n_hc == 2 && m_hc != 2) ? 1 : 0;
    n_ones  = m_ones;
    if (m_vtrig == 1) n_ones = (m_vs == 0) ? 0 : ((m_ones < 50) ? m_ones + 1 : m_ones);
    o_hs   = (m_hc >= 2 && m_hc < 6) ? 1 : 0;
    o_vs   = (m_ones >= 1 && m_ones <= VS_LINES) ? 1 : 0;
    o_cs   = (o_hs == o_vs) ? 1 : 0;
    burst  = (!bus.bw_mode && m_vs == 0 && m_hc >= 7 && m_hc <= 8) ? 1 : 0;
    o_comp = o_cs ? model_level(m_vid, m_ph, burst) : 0;
    m_ph = n_ph; m_vid = n_vid; m_hs = n_hs; m_vs = n_vs;
    m_hc = n_hc; m_vtrig = n_vtrig; m_ones = n_ones;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("comp_video", int'(bus.comp_video), o_comp);
    chk("hsync_out",  int'(bus.hsync_out),  o_hs);
    chk("vsync_out",  int'(bus.vsync_out),  o_vs);
    chk("csync_out",  int'(bus.csync_out),  o_cs);
    chk("pix_strobe", int'(bus.pix_strobe), reset ? 0 : (m_ph % 2));
    if (bus.hsync_out && prev_hs == 0) begin
      hs_rises++;
      if (bus.vsync_out) hs_rises_vs++;
    end
    prev_hs = int'(bus.hsync_out);
    cyc++;
  endtask

  task automatic line(input logic vsl);
    for (int k = 0; k < 10; k++) begin
      bus.hsync   = (k < 7);
      bus.vsync_l = vsl;
      bus.lclk_ce = 1'b1;
      tick();
      bus.lclk_ce = 1'b0;
      tick();
    end
  endtask

  int a [8];
  int b [8];
  int ra, rb, na, hold;

  initial begin
    reset = 1'b1;
    bus.hclk_ce = 1'b0; bus.lclk_ce = 1'b0; bus.video = 4'h0;
    bus.hsync = 1'b0;   bus.vsync_l = 1'b1;
    bus.bw_mode = 1'b0; bus.new_cga = 1'b0; bus.hue = 3'd0;

    // reset behaviour
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_comp", int'(bus.comp_video), 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("post_rst_black", int'(bus.comp_video), 29);
    chk("post_rst_csync", int'(bus.csync_out), 1);

    // long hsync: counter wraps and repeats the pulse
    bus.hclk_ce = 1'b1; bus.hsync = 1'b1;
    hs_rises = 0;
    for (int i = 0; i < 16; i++) begin
      bus.lclk_ce = 1'b1; tick();
      bus.lclk_ce = 1'b0; tick(); tick(); tick();
    end
    chk("hs_wrap_pulses", hs_rises, 2);
    bus.hsync = 1'b0;
    bus.lclk_ce = 1'b1; tick(); tick();
    bus.lclk_ce = 1'b0; tick(); tick();

    // vsync shaping: 2 lines low then 6 lines high
    line(1'b0); line(1'b0);
    chk("vs_cleared", int'(bus.vsync_out), 0);
    hs_rises_vs = 0;
    for (int i = 0; i < 6; i++) line(1'b1);
    chk("vs_3_lines", hs_rises_vs, VS_LINES);

    // black & white, new table, intensity white: flat 113, no burst even in vsync
    bus.video = 4'hF; bus.new_cga = 1'b1; bus.bw_mode = 1'b1;
    bus.hsync = 1'b0; bus.lclk_ce = 1'b1; tick(); tick();
    bus.lclk_ce = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("bw_113", int'(bus.comp_video), 113);
    end
    for (int k = 0; k < 12; k++) begin
      bus.hsync = 1'b1; bus.vsync_l = 1'b0;
      bus.lclk_ce = 1'b1; tick();
      bus.lclk_ce = 1'b0; tick();
      if (o_cs == 1) chk("bw_noburst", int'(bus.comp_video), 113);
    end
    bus.hsync = 1'b0; bus.vsync_l = 1'b1;
    bus.lclk_ce = 1'b1; tick(); tick();
    bus.lclk_ce = 1'b0;

    // hue rotation on red
    bus.bw_mode = 1'b0; bus.new_cga = 1'b0; bus.video = 4'h4; bus.hue = 3'd0;
    for (int i = 0; i < 16; i++) tick();
    while (cyc % 8 != 0) tick();
    for (int i = 0; i < 8; i++) begin tick(); a[i] = int'(bus.comp_video); end
    bus.hue = 3'd2;
    for (int i = 0; i < 8; i++) tick();
    while (cyc % 8 != 0) tick();
    for (int i = 0; i < 8; i++) begin tick(); b[i] = int'(bus.comp_video); end
    ra = -1; rb = -1; na = 0;
    for (int i = 0; i < 8; i++) begin
      if (a[i] == 67) na++;
      if (a[i] == 39 && a[(i + 1) % 8] == 67) ra = (i + 1) % 8;
      if (b[i] == 39 && b[(i + 1) % 8] == 67) rb = (i + 1) % 8;
    end
    chk("red_duty", na, 4);
    chk("hue_shift", (ra - rb + 8) % 8, 2);

    // randomized traffic with a mid-line reset
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      bus.hclk_ce = ($urandom_range(0, 2) == 0);
      bus.lclk_ce = ($urandom_range(0, 3) == 0);
      bus.video   = 4'($urandom_range(0, 15));
      if (hold == 0) begin
        bus.hsync   = ~bus.hsync;
        bus.vsync_l = ($urandom_range(0, 7) != 0);
        hold = $urandom_range(1, 60);
      end else begin
        hold--;
      end
      if (i % 100 == 0) begin
        bus.bw_mode = ($urandom_range(0, 3) == 0);
        bus.new_cga = 1'($urandom_range(0, 1));
        bus.hue     = 3'($urandom_range(0, 7));
      end
      reset = (i == 1500 || i == 1501);
      tick();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
